alu74181_nibble_seq: RTL and testbench
======================================

# alu74181_nibble_seq

Multi-cycle sequencer that drives a single 4-bit `alu74181` slice to compute a wide operation one nibble per clock. It sits on the operand side of the ALU interface: it supplies `a`, `b`, `s`, `cn` and `m`, and consumes `f`, `cn4` and `equal`. It latches a wide operand pair on a start handshake and ripples the slice carry through a register between nibbles. It returns the assembled result with carry and equality flags on a one-cycle done pulse.

## Interface
- `NIBBLES`, default 4: number of nibbles; operand/result width W = 4*NIBBLES (NIBBLES >= 1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op_a`, `op_b`  in  W  operands; latched when start is accepted.
- `op_s`  in  4  74181 function select; latched at start.
- `op_m`  in  1  mode (1 = logic, 0 = arithmetic); latched at start.
- `op_cn`  in  1  carry-in for nibble 0, 74181 active-low convention; latched at start.
- `alu_a`, `alu_b`  out  4  current nibble of the latched operands.
- `alu_s`  out  4  latched select.
- `alu_m`  out  1  latched mode.
- `alu_cn`  out  1  slice carry-in.
- `alu_f`  in  4  slice result; combinational from the alu_* outputs.
- `alu_cn4`  in  1  slice carry-out, active-low.
- `alu_equal`  in  1  slice A=B output (F == 4'hF).
- `result`  out  W  assembled result.
- `carry_out`  out  1  raw `alu_cn4` of the last nibble, active-low.
- `equal_out`  out  1  AND of `alu_equal` over all nibbles.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result and flags are valid while it is high and stay held afterwards.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after the capture of nibble NIBBLES-1.
  - DONE → IDLE unconditionally.
- On start acceptance:
  - latch `op_*` into registers;
  - set nibble index to 0 and the carry register to `op_cn`;
  - clear `result`, set the equal accumulator to 1.
- Drive mapping: `alu_a` = latched A[4i+3:4i] and `alu_b` = latched B[4i+3:4i], where i = index; `alu_cn` = carry register.
- Each RUN edge:
  - result[4i+3:4i] ← `alu_f`;
  - carry register ← `alu_cn4`;
  - equal accumulator ← accumulator & `alu_equal`;
  - index ← i+1.
- At the last capture, `carry_out` ← `alu_cn4` and `equal_out` ← the final accumulator value.
- Carry is passed through regardless of mode; in logic mode the slice ignores it.
- `start` in RUN or DONE is ignored: no queueing, no effect on the operation in flight.
- The index never wraps; it saturates at NIBBLES-1 until IDLE.

## Timing
- Reset values (asynchronous, immediate): state IDLE, index 0; all latched registers, `result`, `carry_out`, `equal_out`, `busy`, `done` and all `alu_*` outputs are 0.
- `start` sampled at edge E0; RUN covers cycles E0..E0+NIBBLES-1, one nibble captured per edge E1..E_NIBBLES.
- `done`=1 and state DONE in the cycle after edge E_NIBBLES; latency from start edge to done = NIBBLES+1 cycles (5 for the default).
- `busy` rises after E0 and falls after the DONE cycle.
- Earliest next start is accepted at the edge ending the cycle after `done` (IDLE) → throughput one operation per NIBBLES+2 cycles.
- Reset asserted mid-operation aborts immediately; no `done` is produced. The next start after release behaves as from power-up.
- `alu_f` is assumed to settle within one cycle of the alu_* outputs changing (purely combinational slice).

## Configuration
- `ALU_SEQ_ZERO_EN`:
  - defined: adds output `zero_out` (1 bit), registered with `done`, = 1 when the assembled `result` is all zeros; reset value 0.
  - undefined: port absent; all other behaviour identical.

## Test plan
Bench instantiates `alu74181_nibble_seq` with `alu74181` wired to the alu_* ports, NIBBLES=4.
- Add, S=1001 M=0 Cn=1, A=16'h1234 B=16'h0FFF → `result`=16'h2233, `carry_out`=1, `done` exactly 5 cycles after the start edge, `busy` high throughout.
- Add, S=1001 M=0 Cn=1, A=16'hFFFF B=16'h0001 → `result`=16'h0000, `carry_out`=0; `zero_out`=1 when `ALU_SEQ_ZERO_EN` is defined.
- A minus B minus 1, S=0110 M=0 Cn=1, A=B=16'h5A5A → `result`=16'hFFFF, `equal_out`=1. Repeat with B=16'h5A5B → `equal_out`=0.
- Logic XOR, M=1 S=0110, A=16'hF0F0 B=16'hFF00 → `result`=16'h0FF0, `done` pulse width exactly 1 cycle.
- `start` re-asserted during RUN with different operands → first result unaffected, no second `done`. Then `rst_n` pulsed low in the 2nd RUN cycle of a new operation → all outputs 0 immediately, no `done`; a following add 16'h0001+16'h0001 → 16'h0002.

Source files
------------

// File: rtl/alu74181_nibble_seq_if.sv
// Bus bundle between the nibble sequencer, its requester and the 4-bit 74181 slice.
// Optional zero_out member is present only when ALU_SEQ_ZERO_EN is defined.
interface alu74181_nibble_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  // Request side
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_s;
  logic         op_m;
  logic         op_cn;

  // Slice side
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cn;
  logic [3:0]   alu_f;
  logic         alu_cn4;
  logic         alu_equal;

  // Completion side
  logic [W-1:0] result;
  logic         carry_out;
  logic         equal_out;
  logic         busy;
  logic         done;
`ifdef ALU_SEQ_ZERO_EN
  logic         zero_out;
`endif

  // Sequencer view
  modport master (
    input  start, op_a, op_b, op_s, op_m, op_cn,
    input  alu_f, alu_cn4, alu_equal,
    output alu_a, alu_b, alu_s, alu_m, alu_cn,
    output result, carry_out, equal_out, busy, done
`ifdef ALU_SEQ_ZERO_EN
    , output zero_out
`endif
  );

  // Requester / slice view
  modport slave (
    output start, op_a, op_b, op_s, op_m, op_cn,
    output alu_f, alu_cn4, alu_equal,
    input  alu_a, alu_b, alu_s, alu_m, alu_cn,
    input  result, carry_out, equal_out, busy, done
`ifdef ALU_SEQ_ZERO_EN
    , input zero_out
`endif
  );
endinterface

// File: rtl/alu74181_nibble_seq.sv
// Drives one 4-bit 74181 slice over NIBBLES clocks to compute a wide operation,
// rippling the active-low slice carry through a register between nibbles.
// Optional feature macro: ALU_SEQ_ZERO_EN adds a registered all-zero result flag.
module alu74181_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu74181_nibble_seq_if.master   bus
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [3:0]      s_q, s_d;
  logic            m_q, m_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            eq_acc_q, eq_acc_d;
  logic            carry_out_q, carry_out_d;
  logic            equal_out_q, equal_out_d;
`ifdef ALU_SEQ_ZERO_EN
  logic            zero_q, zero_d;
`endif

  logic accept;
  logic last_nib;

  assign accept   = (state_q == StIdle) && bus.start;
  assign last_nib = (idx_q == LastIdx);

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      eq_acc_q    <= 1'b0;
      carry_out_q <= 1'b0;
      equal_out_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      m_q         <= m_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      eq_acc_q    <= eq_acc_d;
      carry_out_q <= carry_out_d;
      equal_out_q <= equal_out_d;
`ifdef ALU_SEQ_ZERO_EN
      zero_q      <= zero_d;
`endif
    end
  end

  // FSM next state: one RUN cycle per nibble, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_nib) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state: latch on accept, capture one nibble per RUN edge
  always_comb begin
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    m_d         = m_q;
    carry_d     = carry_q;
    result_d    = result_q;
    eq_acc_d    = eq_acc_q;
    carry_out_d = carry_out_q;
    equal_out_d = equal_out_q;
`ifdef ALU_SEQ_ZERO_EN
    zero_d      = zero_q;
`endif
    if (accept) begin
      a_d      = bus.op_a;
      b_d      = bus.op_b;
      s_d      = bus.op_s;
      m_d      = bus.op_m;
      carry_d  = bus.op_cn;
      idx_d    = '0;
      result_d = '0;
      eq_acc_d = 1'b1;
`ifdef ALU_SEQ_ZERO_EN
      zero_d   = 1'b0;
`endif
    end else if (state_q == StRun) begin
      for (int i = 0; i < int'(NIBBLES); i++) begin
        if (idx_q == IdxW'(i)) result_d[4*i +: 4] = bus.alu_f;
      end
      carry_d  = bus.alu_cn4;
      eq_acc_d = eq_acc_q & bus.alu_equal;
      if (last_nib) begin
        // Index saturates here until the next accept
        carry_out_d = bus.alu_cn4;
        equal_out_d = eq_acc_d;
`ifdef ALU_SEQ_ZERO_EN
        zero_d      = (result_d == '0);
`endif
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  // Slice operand mux: current nibble of the latched operands
  always_comb begin
    bus.alu_a = 4'h0;
    bus.alu_b = 4'h0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx_q == IdxW'(i)) begin
        bus.alu_a = a_q[4*i +: 4];
        bus.alu_b = b_q[4*i +: 4];
      end
    end
  end

  assign bus.alu_s     = s_q;
  assign bus.alu_m     = m_q;
  assign bus.alu_cn    = carry_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.equal_out = equal_out_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
`ifdef ALU_SEQ_ZERO_EN
  assign bus.zero_out  = zero_q;
`endif

endmodule

// File: tb/tb_alu74181_nibble_seq.sv
// Directed bench for alu74181_nibble_seq with a behavioural 74181 slice model.
module tb_alu74181_nibble_seq;
  localparam int unsigned Nibbles = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu74181_nibble_seq_if #(.NIBBLES(Nibbles)) bus ();

  alu74181_nibble_seq #(.NIBBLES(Nibbles)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 74181 slice, active-high data: arithmetic F = X + Y + ~Cn, logic F = ~(X ^ Y)
  logic [3:0] sl_x, sl_y, sl_f;
  logic [4:0] sl_sum;
  always_comb begin
    sl_x = bus.alu_a | (bus.alu_b & {4{bus.alu_s[0]}}) | (~bus.alu_b & {4{bus.alu_s[1]}});
    sl_y = (bus.alu_a & bus.alu_b & {4{bus.alu_s[3]}}) |
           (bus.alu_a & ~bus.alu_b & {4{bus.alu_s[2]}});
    sl_sum = {1'b0, sl_x} + {1'b0, sl_y} + {4'b0, ~bus.alu_cn};
    sl_f   = bus.alu_m ? ~(sl_x ^ sl_y) : sl_sum[3:0];
    bus.alu_f     = sl_f;
    bus.alu_cn4   = ~sl_sum[4];
    bus.alu_equal = &sl_f;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one operation; returns start-to-done latency (-1 on timeout) and busy history
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                       input logic m, input logic cn, output int lat, output logic busy_ok);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.op_s = s; bus.op_m = m; bus.op_cn = cn;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    busy_ok = bus.busy;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k + 1;  // count the cycle in which start was sampled
        break;
      end
      busy_ok &= bus.busy;
    end
    busy_ok &= bus.busy;
  endtask

  int   lat;
  logic busy_ok;
  int   n_done;
  logic [15:0] first_res;

  initial begin
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_s = '0; bus.op_m = 1'b0;
    bus.op_cn = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_result", 32'(bus.result), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_alu_cn", 32'(bus.alu_cn), 32'h0);
    check("rst_alu_s", 32'(bus.alu_s), 32'h0);
    check("rst_flags", 32'({bus.carry_out, bus.equal_out}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add with no overflow
    do_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, lat, busy_ok);
    check("add1_result", 32'(bus.result), 32'h2233);
    check("add1_carry", 32'(bus.carry_out), 32'h1);
    check("add1_latency", 32'(lat), 32'd5);
    check("add1_busy", 32'(busy_ok), 32'h1);
`ifdef ALU_SEQ_ZERO_EN
    check("add1_zero", 32'(bus.zero_out), 32'h0);
`endif

    // Add with wrap to zero
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, lat, busy_ok);
    check("add2_result", 32'(bus.result), 32'h0000);
    check("add2_carry", 32'(bus.carry_out), 32'h0);
`ifdef ALU_SEQ_ZERO_EN
    check("add2_zero", 32'(bus.zero_out), 32'h1);
`endif

    // A minus B minus 1
    do_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, lat, busy_ok);
    check("sub_eq_result", 32'(bus.result), 32'hFFFF);
    check("sub_eq_equal", 32'(bus.equal_out), 32'h1);
    check("sub_eq_carry", 32'(bus.carry_out), 32'h1);
    do_op(16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, lat, busy_ok);
    check("sub_ne_result", 32'(bus.result), 32'hFFFE);
    check("sub_ne_equal", 32'(bus.equal_out), 32'h0);

    // Logic XOR and done pulse width
    do_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, lat, busy_ok);
    check("xor_result", 32'(bus.result), 32'h0FF0);
    check("xor_latency", 32'(lat), 32'd5);
    @(negedge clk);
    check("xor_done_width", 32'(bus.done), 32'h0);
    check("xor_busy_fall", 32'(bus.busy), 32'h0);
    check("xor_result_held", 32'(bus.result), 32'h0FF0);

    // start held through RUN with other operands: must be ignored
    @(negedge clk);
    bus.op_a = 16'h1234; bus.op_b = 16'h0FFF; bus.op_s = 4'b1001; bus.op_m = 1'b0;
    bus.op_cn = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.op_s = 4'b0110; bus.op_m = 1'b1;
    n_done = 0;
    first_res = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) bus.start = 1'b0;
      if (bus.done) begin
        if (n_done == 0) first_res = bus.result;
        n_done++;
      end
    end
    check("ignore_start_result", 32'(first_res), 32'h2233);
    check("ignore_start_ndone", 32'(n_done), 32'd1);
    check("ignore_start_idle", 32'(bus.busy), 32'h0);

    // Reset in the second RUN cycle aborts immediately
    @(negedge clk);
    bus.op_a = 16'hFFFF; bus.op_b = 16'hFFFF; bus.op_s = 4'b1001; bus.op_m = 1'b0;
    bus.op_cn = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", 32'(bus.result), 32'h0);
    check("abort_busy_done", 32'({bus.busy, bus.done}), 32'h0);
    check("abort_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_cn}), 32'h0);
    check("abort_flags", 32'({bus.carry_out, bus.equal_out}), 32'h0);
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (bus.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    do_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, lat, busy_ok);
    check("post_rst_result", 32'(bus.result), 32'h0002);
    check("post_rst_latency", 32'(lat), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
